// File: rtl/wb_merge_unit.sv
// Writeback merge unit: per-source FIFOs feeding a round-robin arbiter that drives
// a single valid/ready scoreboard write port, with the grant held stable while stalled.
module wb_merge_unit #(
    parameter int NR_SRC        = 4,
    parameter int DEPTH         = 2,
    parameter int XLEN          = 32,
    parameter int TRANS_ID_BITS = 3
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            flush_i,
    input  logic [NR_SRC-1:0]               src_valid_i,
    input  logic [NR_SRC*TRANS_ID_BITS-1:0] src_trans_id_i,
    input  logic [NR_SRC*XLEN-1:0]          src_result_i,
    input  logic [NR_SRC-1:0]               src_ex_valid_i,
    input  logic [NR_SRC*XLEN-1:0]          src_ex_cause_i,
    output logic [NR_SRC-1:0]               src_almost_full_o,
    output logic [NR_SRC-1:0]               src_overflow_o,
    output logic                            wb_valid_o,
    input  logic                            wb_ready_i,
    output logic [TRANS_ID_BITS-1:0]        wb_trans_id_o,
    output logic [XLEN-1:0]                 wb_result_o,
    output logic                            wb_ex_valid_o,
    output logic [XLEN-1:0]                 wb_ex_cause_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [XLEN-1:0]          result;
        logic                     ex_valid;
        logic [XLEN-1:0]          ex_cause;
    } entry_t;

    entry_t            mem_q    [NR_SRC][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [NR_SRC];
    logic [PTR_W-1:0]  rd_ptr_q [NR_SRC];
    logic [CNT_W-1:0]  cnt_q    [NR_SRC];

    entry_t            src_entry [NR_SRC];
    entry_t            head      [NR_SRC];
    entry_t            sel;

    logic [NR_SRC-1:0] empty;
    logic [NR_SRC-1:0] full;
    logic [NR_SRC-1:0] push;
    logic [NR_SRC-1:0] pop;
    logic [NR_SRC-1:0] drop;
    logic [NR_SRC-1:0] overflow_q;

    logic [IDX_W-1:0]  rr_ptr_q;
    logic [IDX_W-1:0]  lock_grant_q;
    logic              lock_q;
    logic [IDX_W-1:0]  rr_grant;
    logic [IDX_W-1:0]  cand;
    logic              found;
    logic [IDX_W-1:0]  grant;
    logic              transfer;

    always_comb begin
        for (int k = 0; k < NR_SRC; k++) begin
            src_entry[k].trans_id = src_trans_id_i[k*TRANS_ID_BITS +: TRANS_ID_BITS];
            src_entry[k].result   = src_result_i[k*XLEN +: XLEN];
            src_entry[k].ex_valid = src_ex_valid_i[k];
            src_entry[k].ex_cause = src_ex_cause_i[k*XLEN +: XLEN];
            head[k]               = mem_q[k][rd_ptr_q[k]];
            empty[k]              = (cnt_q[k] == '0);
            full[k]               = (cnt_q[k] == CNT_W'(DEPTH));
            src_almost_full_o[k]  = (cnt_q[k] >= CNT_W'(DEPTH - 1));
        end
    end

    // Round-robin scan starts just after the last source that transferred.
    always_comb begin
        rr_grant = '0;
        cand     = '0;
        found    = 1'b0;
        for (int i = 1; i <= NR_SRC; i++) begin
            cand = IDX_W'((int'(rr_ptr_q) + i) % NR_SRC);
            if (!found && !empty[cand]) begin
                rr_grant = cand;
                found    = 1'b1;
            end
        end
    end

    assign grant      = lock_q ? lock_grant_q : rr_grant;
    assign wb_valid_o = (|(~empty)) & ~flush_i;
    assign transfer   = wb_valid_o & wb_ready_i;
    assign sel        = head[grant];

    assign wb_trans_id_o  = sel.trans_id;
    assign wb_result_o    = sel.result;
    assign wb_ex_valid_o  = sel.ex_valid;
    assign wb_ex_cause_o  = sel.ex_cause;
    assign src_overflow_o = overflow_q;

    // A full FIFO may still accept a push when its head leaves in the same cycle.
    always_comb begin
        for (int k = 0; k < NR_SRC; k++) begin
            pop[k]  = transfer && (grant == IDX_W'(k));
            push[k] = src_valid_i[k] && !flush_i && (!full[k] || pop[k]);
            drop[k] = src_valid_i[k] && !flush_i && full[k] && !pop[k];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            for (int k = 0; k < NR_SRC; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < NR_SRC; k++) begin
                if (push[k]) wr_ptr_q[k] <= wr_ptr_q[k] + PTR_W'(1);
                if (pop[k])  rd_ptr_q[k] <= rd_ptr_q[k] + PTR_W'(1);
                case ({push[k], pop[k]})
                    2'b10:   cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                    2'b01:   cnt_q[k] <= cnt_q[k] - CNT_W'(1);
                    default: cnt_q[k] <= cnt_q[k];
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NR_SRC; k++) begin
            if (!rst_i && push[k]) mem_q[k][wr_ptr_q[k]] <= src_entry[k];
        end
    end

    // The lock freezes the grant while the scoreboard stalls a presented entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q     <= IDX_W'(NR_SRC - 1);
            lock_q       <= 1'b0;
            lock_grant_q <= '0;
            overflow_q   <= '0;
        end else begin
            overflow_q <= overflow_q | drop;
            if (flush_i) begin
                lock_q <= 1'b0;
            end else if (transfer) begin
                rr_ptr_q <= grant;
                lock_q   <= 1'b0;
            end else if (wb_valid_o) begin
                lock_q       <= 1'b1;
                lock_grant_q <= grant;
            end
        end
    end

endmodule

// File: tb/tb_wb_merge_unit.sv
// Randomized scoreboard bench for wb_merge_unit: per-source reference queues, with a
// negedge monitor that picks the expected winner by round-robin over the queues.
module tb_wb_merge_unit;

    localparam int NR_SRC = 4;
    localparam int DEPTH  = 2;
    localparam int XLEN   = 32;
    localparam int TIDB   = 3;

    typedef struct {
        logic [TIDB-1:0] id;
        logic [XLEN-1:0] res;
        logic            exv;
        logic [XLEN-1:0] cause;
    } entry_t;

    logic                   clk_i;
    logic                   rst_i;
    logic                   flush_i;
    logic [NR_SRC-1:0]      src_valid_i;
    logic [NR_SRC*TIDB-1:0] src_trans_id_i;
    logic [NR_SRC*XLEN-1:0] src_result_i;
    logic [NR_SRC-1:0]      src_ex_valid_i;
    logic [NR_SRC*XLEN-1:0] src_ex_cause_i;
    logic [NR_SRC-1:0]      src_almost_full_o;
    logic [NR_SRC-1:0]      src_overflow_o;
    logic                   wb_valid_o;
    logic                   wb_ready_i;
    logic [TIDB-1:0]        wb_trans_id_o;
    logic [XLEN-1:0]        wb_result_o;
    logic                   wb_ex_valid_o;
    logic [XLEN-1:0]        wb_ex_cause_o;

    wb_merge_unit #(
        .NR_SRC(NR_SRC), .DEPTH(DEPTH), .XLEN(XLEN), .TRANS_ID_BITS(TIDB)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .flush_i(flush_i),
        .src_valid_i(src_valid_i),
        .src_trans_id_i(src_trans_id_i),
        .src_result_i(src_result_i),
        .src_ex_valid_i(src_ex_valid_i),
        .src_ex_cause_i(src_ex_cause_i),
        .src_almost_full_o(src_almost_full_o),
        .src_overflow_o(src_overflow_o),
        .wb_valid_o(wb_valid_o),
        .wb_ready_i(wb_ready_i),
        .wb_trans_id_o(wb_trans_id_o),
        .wb_result_o(wb_result_o),
        .wb_ex_valid_o(wb_ex_valid_o),
        .wb_ex_cause_o(wb_ex_cause_o)
    );

    entry_t            sb_q [NR_SRC][$];
    entry_t            stim_e [NR_SRC];
    logic [NR_SRC-1:0] ov_model;
    int                checks = 0;
    int                errors = 0;
    int                last_grant = NR_SRC - 1;
    int                locked = -1;
    logic              rst_prev = 1'b0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic rand_entry(input int k);
        stim_e[k].id    = TIDB'($urandom_range(0, 7));
        stim_e[k].res   = $urandom;
        stim_e[k].exv   = 1'($urandom_range(0, 1));
        stim_e[k].cause = $urandom;
    endtask

    // Drive one cycle of inputs, then account for what the edge accepts.
    task automatic apply_stimulus(input logic r, input logic f, input logic rdy, input logic [NR_SRC-1:0] v);
        rst_i       = r;
        flush_i     = f;
        wb_ready_i  = rdy;
        src_valid_i = v;
        for (int k = 0; k < NR_SRC; k++) begin
            src_trans_id_i[k*TIDB +: TIDB] = stim_e[k].id;
            src_result_i[k*XLEN +: XLEN]   = stim_e[k].res;
            src_ex_valid_i[k]              = stim_e[k].exv;
            src_ex_cause_i[k*XLEN +: XLEN] = stim_e[k].cause;
        end
        @(posedge clk_i);
        if (r) begin
            for (int k = 0; k < NR_SRC; k++) sb_q[k].delete();
            ov_model = '0;
        end else if (f) begin
            for (int k = 0; k < NR_SRC; k++) sb_q[k].delete();
        end else begin
            for (int k = 0; k < NR_SRC; k++) begin
                if (v[k]) begin
                    if (sb_q[k].size() < DEPTH) sb_q[k].push_back(stim_e[k]);
                    else ov_model[k] = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, rdy, '0);
    endtask

    // Monitor: flags every cycle, head data of the expected winner when valid.
    always @(negedge clk_i) begin : monitor
        int g;
        logic any;
        logic exp_valid;
        logic [NR_SRC-1:0] af_exp;
        if (rst_i) begin
            if (rst_prev) begin
                check_output("reset_wb_valid", 64'(wb_valid_o), 64'd0);
                check_output("reset_almost_full", 64'(src_almost_full_o), 64'd0);
                check_output("reset_overflow", 64'(src_overflow_o), 64'd0);
            end
            rst_prev   = 1'b1;
            locked     = -1;
            last_grant = NR_SRC - 1;
        end else begin
            rst_prev = 1'b0;
            any = 1'b0;
            for (int k = 0; k < NR_SRC; k++) begin
                af_exp[k] = (sb_q[k].size() >= DEPTH - 1);
                if (sb_q[k].size() > 0) any = 1'b1;
            end
            g = -1;
            if (locked >= 0) g = locked;
            else begin
                for (int i = 1; i <= NR_SRC; i++) begin
                    int c;
                    c = (last_grant + i) % NR_SRC;
                    if (g < 0 && sb_q[c].size() > 0) g = c;
                end
            end
            exp_valid = any && !flush_i;
            check_output("wb_valid", 64'(wb_valid_o), 64'(exp_valid));
            check_output("almost_full", 64'(src_almost_full_o), 64'(af_exp));
            check_output("overflow", 64'(src_overflow_o), 64'(ov_model));
            if (exp_valid) begin
                check_output("wb_trans_id", 64'(wb_trans_id_o), 64'(sb_q[g][0].id));
                check_output("wb_result", 64'(wb_result_o), 64'(sb_q[g][0].res));
                check_output("wb_ex_valid", 64'(wb_ex_valid_o), 64'(sb_q[g][0].exv));
                check_output("wb_ex_cause", 64'(wb_ex_cause_o), 64'(sb_q[g][0].cause));
                if (wb_ready_i) begin
                    void'(sb_q[g].pop_front());
                    last_grant = g;
                    locked     = -1;
                end else begin
                    locked = g;
                end
            end
            if (flush_i) locked = -1;
        end
    end

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; wb_ready_i = 1'b0; src_valid_i = '0;
        src_trans_id_i = '0; src_result_i = '0; src_ex_valid_i = '0; src_ex_cause_i = '0;
        ov_model = '0;
        for (int k = 0; k < NR_SRC; k++) rand_entry(k);

        // Reset held two cycles with every source pulsing
        apply_stimulus(1'b1, 1'b0, 1'b1, 4'b1111);
        apply_stimulus(1'b1, 1'b0, 1'b1, 4'b1111);
        idle(3, 1'b1);

        // Single push from source 1
        stim_e[1].id = 3'd5; stim_e[1].res = 32'hDEADBEEF; stim_e[1].exv = 1'b0; stim_e[1].cause = '0;
        apply_stimulus(1'b0, 1'b0, 1'b1, 4'b0010);
        idle(2, 1'b1);

        // Round-robin from a fresh pointer
        apply_stimulus(1'b1, 1'b0, 1'b1, '0);
        for (int k = 0; k < NR_SRC; k++) rand_entry(k);
        apply_stimulus(1'b0, 1'b0, 1'b1, 4'b1111);
        idle(5, 1'b1);

        // Stall lock on source 2 while source 0 arrives
        for (int k = 0; k < NR_SRC; k++) rand_entry(k);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0100);
        idle(2, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0001);
        idle(2, 1'b0);
        idle(3, 1'b1);

        // Overflow on source 0
        apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        for (int id = 1; id <= 3; id++) begin
            rand_entry(0);
            stim_e[0].id = TIDB'(id);
            apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0001);
        end
        idle(1, 1'b0);
        idle(3, 1'b1);

        // Flush with three FIFOs pending
        for (int k = 0; k < NR_SRC; k++) rand_entry(k);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b1011);
        idle(1, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b1, '0);
        idle(2, 1'b1);
        rand_entry(2);
        apply_stimulus(1'b0, 1'b0, 1'b1, 4'b0100);
        idle(3, 1'b1);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            logic [NR_SRC-1:0] v;
            for (int k = 0; k < NR_SRC; k++) begin
                rand_entry(k);
                v[k] = ($urandom_range(0, 99) < 35);
            end
            apply_stimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 49) == 0),
                           ($urandom_range(0, 99) < 70), v);
        end
        idle(4, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
